// File: rtl/sram_serial_io_ctrl.sv
// Serial-to-parallel access controller for a 512x8 single-port synchronous SRAM.
// A 17-bit {addr, data} frame is shifted in LSB first, then one SRAM write or read is performed.
module sram_serial_io_ctrl #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic                         BGN,
  input  logic                         SI,
  input  logic                         LOAD_N,
  input  logic [1:0]                   CTRL,
  input  logic [MEMORY_DATA_WIDTH-1:0] PI,
  output logic                         RDY,
  output logic                         D_WE,
  output logic                         CEN,
  output logic                         SO,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] PO
);

  localparam int CNT_W = $clog2(REG_BITS_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(REG_BITS_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_ACCESS,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [REG_BITS_WIDTH-1:0] r_sr;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_rdy;
  logic                      r_cen;
  logic                      r_we;
  logic                      w_single_frame;

  // Every CTRL code currently decodes to single-frame access; reserved codes alias 2'b00.
  always_comb begin
    w_single_frame = 1'b1;
    case (CTRL)
      2'b00:   w_single_frame = 1'b1;
      default: w_single_frame = 1'b1;
    endcase
  end

  // NOTE: all state, including the shift register, updates with non-blocking assignments so
  // every flop samples pre-edge values; reset clears r_cen at once, cancelling an in-flight access.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_rdy   <= 1'b0;
      r_cen   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_rdy <= 1'b0;
          r_cen <= 1'b0;
          r_we  <= 1'b0;
          if (BGN && w_single_frame) r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (!BGN) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_sr <= {SI, r_sr[REG_BITS_WIDTH-1:1]};
            if (r_cnt == LAST_SHIFT) begin
              r_cnt   <= '0;
              r_cen   <= 1'b1;
              r_we    <= ~LOAD_N;
              r_state <= S_ACCESS;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_ACCESS: begin
          // The SRAM acts on this edge; strobes drop whatever comes next.
          r_cen <= 1'b0;
          r_we  <= 1'b0;
          if (!BGN) begin
            r_state <= S_IDLE;
          end else if (r_we) begin
            r_rdy   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (!BGN) begin
            r_state <= S_IDLE;
          end else begin
            r_sr[MEMORY_DATA_WIDTH-1:0] <= PI;
            r_rdy                       <= 1'b1;
            r_state                     <= S_DONE;
          end
        end
        S_DONE: begin
          if (!BGN) begin
            r_rdy   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign RDY  = r_rdy;
  assign CEN  = r_cen;
  assign D_WE = r_we;
  assign SO   = r_sr[0];
  assign A    = r_sr[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH];
  assign PO   = r_sr[MEMORY_DATA_WIDTH-1:0];

endmodule

// File: tb/tb_sram_serial_io_ctrl.sv
// Self-checking bench for sram_serial_io_ctrl: behavioural SRAM macro plus a frame-level
// reference model of memory contents and shift-register state.
module tb_sram_serial_io_ctrl;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       BGN;
  logic       SI;
  logic       LOAD_N;
  logic [1:0] CTRL;
  logic [7:0] PI;
  logic       RDY;
  logic       D_WE;
  logic       CEN;
  logic       SO;
  logic [8:0] A;
  logic [7:0] PO;

  sram_serial_io_ctrl dut (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .BGN    (BGN),
    .SI     (SI),
    .LOAD_N (LOAD_N),
    .CTRL   (CTRL),
    .PI     (PI),
    .RDY    (RDY),
    .D_WE   (D_WE),
    .CEN    (CEN),
    .SO     (SO),
    .A      (A),
    .PO     (PO)
  );

  always #5 CLK = ~CLK;

  // SRAM macro: registered read, write on the edge where CEN and D_WE are high.
  logic [7:0] mem [512];
  logic [7:0] q = 8'h00;
  assign PI = q;

  always @(posedge CLK) begin
    if (CEN === 1'b1) begin
      if (D_WE === 1'b1) mem[A] <= PO;
      else               q      <= mem[A];
    end
  end

  // Access monitor: counts SRAM cycles and records what each one saw.
  int         cen_cnt = 0;
  logic [8:0] last_a  = '0;
  logic [7:0] last_po = '0;
  logic       last_we = 1'b0;

  always @(posedge CLK) begin
    if (CEN === 1'b1) begin
      cen_cnt <= cen_cnt + 1;
      last_a  <= A;
      last_po <= PO;
      last_we <= D_WE;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [7:0]  exp_mem [512];
  logic [16:0] exp_sr;
  logic [8:0]  written_q [$];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs one frame. abort_after < 0 runs the full frame; otherwise BGN drops after that many shifts.
  task automatic run_frame(input logic [8:0] addr, input logic [7:0] data, input logic load_n,
                           input logic [1:0] ctrl, input int abort_after);
    logic [16:0] frame;
    logic [16:0] old_sr;
    logic [16:0] so_seen;
    logic [16:0] mask;
    int          c0;
    int          shifts;
    int          edges;
    frame   = {addr, data};
    old_sr  = exp_sr;
    so_seen = '0;
    c0      = cen_cnt;
    shifts  = (abort_after < 0) ? 17 : abort_after;
    LOAD_N  = load_n;
    CTRL    = ctrl;
    BGN     = 1'b1;
    step();
    for (int j = 0; j < shifts; j++) begin
      so_seen[j] = SO;
      SI         = frame[j];
      step();
    end
    mask = (17'h1 << shifts) - 17'h1;
    if (shifts == 17) mask = '1;
    check("so_chain", 32'(so_seen & mask), 32'(old_sr & mask));

    if (abort_after >= 0) begin
      BGN = 1'b0;
      step();
      check("abort_no_access", 32'(cen_cnt - c0), 32'd0);
      check("abort_rdy", 32'(RDY), 32'd0);
      exp_sr = (exp_sr >> shifts) | ((frame & mask) << (17 - shifts));
      check("abort_sr", 32'({A, PO}), 32'(exp_sr));
      return;
    end

    check("access_cen", 32'(CEN), 32'd1);
    check("access_we", 32'(D_WE), 32'(!load_n));
    edges = 0;
    while (RDY !== 1'b1 && edges < 6) begin
      step();
      edges++;
    end
    check("rdy_latency", 32'(edges), load_n ? 32'd2 : 32'd1);
    check("access_count", 32'(cen_cnt - c0), 32'd1);
    check("access_addr", 32'(last_a), 32'(addr));
    check("access_we_seen", 32'(last_we), 32'(!load_n));
    if (!load_n) begin
      check("access_po", 32'(last_po), 32'(data));
      exp_mem[addr] = data;
      written_q.push_back(addr);
      exp_sr = frame;
    end else begin
      exp_sr = {addr, exp_mem[addr]};
    end
    check("done_a", 32'(A), 32'(addr));
    check("done_po", 32'(PO), 32'(exp_sr[7:0]));

    step();
    step();
    check("done_hold", 32'({RDY, CEN, D_WE}), 32'b100);
    check("done_count", 32'(cen_cnt - c0), 32'd1);
    BGN = 1'b0;
    step();
    check("rdy_clear", 32'(RDY), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] snap;
    logic [8:0] ra;
    logic [7:0] rd;
    int         c0;

    // Reset with BGN high and SI toggling: nothing may move.
    rst_n  = 1'b0;
    BGN    = 1'b1;
    SI     = 1'b0;
    LOAD_N = 1'b0;
    CTRL   = 2'b00;
    for (int i = 0; i < 6; i++) begin
      SI = ~SI;
      step();
    end
    check("reset_outputs", 32'({RDY, CEN, D_WE, SO}), 32'd0);
    check("reset_a", 32'(A), 32'd0);
    check("reset_po", 32'(PO), 32'd0);
    check("reset_no_access", 32'(cen_cnt), 32'd0);
    BGN    = 1'b0;
    rst_n  = 1'b1;
    exp_sr = '0;
    step();

    // Basic write
    run_frame(9'h020, 8'h34, 1'b0, 2'b00, -1);
    check("mem_020", 32'(mem[9'h020]), 32'h34);

    // Program preload of 14 bytes, then direct readback of the array.
    for (int i = 0; i < 14; i++)
      run_frame(9'(9'h020 + i), 8'($urandom), 1'b0, 2'($urandom), -1);
    for (int i = 0; i < 14; i++)
      check("preload", 32'(mem[9'h020 + i]), 32'(exp_mem[9'h020 + i]));

    // Read at top address; next frame must shift out 0xA5 then 0x1FF.
    run_frame(9'h1FF, 8'hA5, 1'b0, 2'b00, -1);
    run_frame(9'h1FF, 8'h00, 1'b1, 2'b00, -1);
    check("read_1ff", 32'(PO), 32'hA5);
    run_frame(9'h000, 8'h5A, 1'b0, 2'b11, -1);
    check("mem_000", 32'(mem[9'h000]), 32'h5A);

    // Abort after 10 shifts, then a complete frame to the same address.
    snap = mem[9'h0AA];
    run_frame(9'h0AA, 8'h11, 1'b0, 2'b00, 10);
    check("abort_mem", 32'(mem[9'h0AA]), 32'(snap));
    run_frame(9'h0AA, 8'h22, 1'b0, 2'b01, -1);
    check("mem_0aa", 32'(mem[9'h0AA]), 32'h22);

    // Randomized mix of writes and reads of already-written addresses.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ra = 9'($urandom);
        rd = 8'($urandom);
        run_frame(ra, rd, 1'b0, 2'($urandom), -1);
      end else begin
        ra = written_q[$urandom_range(0, written_q.size() - 1)];
        run_frame(ra, 8'($urandom), 1'b1, 2'($urandom), -1);
      end
    end

    // Reset during the ACCESS cycle of a write.
    snap   = mem[9'h030];
    c0     = cen_cnt;
    LOAD_N = 1'b0;
    BGN    = 1'b1;
    step();
    for (int j = 0; j < 17; j++) begin
      SI = (j < 8) ? 1'b1 : ((j == 12 || j == 13) ? 1'b1 : 1'b0);
      step();
    end
    check("mid_access_cen", 32'(CEN), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_cen_we", 32'({CEN, D_WE}), 32'd0);
    check("rst_rdy", 32'(RDY), 32'd0);
    check("rst_addr", 32'(A), 32'd0);
    step();
    step();
    check("rst_no_access", 32'(cen_cnt - c0), 32'd0);
    check("rst_mem", 32'(mem[9'h030]), 32'(snap));
    BGN    = 1'b0;
    rst_n  = 1'b1;
    exp_sr = '0;
    step();
    run_frame(9'h031, 8'h7E, 1'b0, 2'b00, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
